note_table_sequencer: RTL and testbench
=======================================

// Module: note_table_sequencer
// PURPOSE
//  Walks a table of note entries {x, y, key id} held in external synchronous ROMs, one entry per handshake.
//  Generalises the fixed 16-entry location walker: depth, field widths and ROM latency are parameters.
//  Adds a valid/ready output handshake, one-shot or wrap mode, an optional end-of-table marker and abort.
//  Sits between the note-table ROMs and the sprite draw FSM.
// PARAMETERS
//  N_ENTRIES    16  table depth (>=2); IDX_W = $clog2(N_ENTRIES) is a localparam
//  X_W          8   x-coordinate width
//  Y_W          8   y-coordinate width
//  ID_W         2   key-id width (selects the key sprite ROM)
//  RD_LAT       1   ROM read latency in cycles, 1..3
//  WRAP         0   1: restart at index 0 after the last entry; 0: one-shot, then done
//  USE_END_MARK 1   1: an entry with x == all-ones terminates the table early
// PORTS
//  clock      in   1      sole clock, rising edge
//  reset      in   1      synchronous, active-high
//  start      in   1      begin a walk from index 0 (sampled in IDLE only)
//  stop       in   1      abort the walk; no done pulse
//  tbl_rd     out  1      one-cycle read strobe to the ROMs
//  tbl_addr   out  IDX_W  ROM address, valid while tbl_rd=1
//  tbl_x      in   X_W    ROM x data, valid RD_LAT cycles after tbl_rd
//  tbl_y      in   Y_W    ROM y data, same timing
//  tbl_id     in   ID_W   ROM key-id data, same timing
//  out_valid  out  1      entry presented on out_*
//  out_ready  in   1      consumer accepts the entry
//  out_x      out  X_W    registered entry x
//  out_y      out  Y_W    registered entry y
//  out_id     out  ID_W   registered entry key id
//  out_idx    out  IDX_W  table index of the presented entry
//  out_last   out  1      presented entry is index N_ENTRIES-1 (always 0 when WRAP=1)
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse when a one-shot walk completes
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; idx 0; latency pipe cleared. Reset mid-walk abandons any in-flight read.
//  - States: IDLE -> FETCH -> WAIT -> PRESENT -> (FETCH | DONE); DONE -> IDLE.
//  - IDLE: start=1 -> FETCH with idx=0. start is ignored in every other state.
//  - FETCH (1 cycle): tbl_rd=1, tbl_addr=idx -> WAIT.
//  - WAIT: tbl_rd=0; tbl_* captured at the end of the cycle RD_LAT cycles after the FETCH cycle.
//    On capture: if USE_END_MARK and tbl_x == {X_W{1'b1}}, treat it as past-the-end (no PRESENT).
//    Otherwise load out_* and out_idx, set out_last, -> PRESENT.
//  - PRESENT: out_valid=1; out_* held stable until out_valid & out_ready. On that handshake, next cycle:
//    - idx < N_ENTRIES-1: idx+1, FETCH.
//    - idx == N_ENTRIES-1 or end marker: WRAP=1 -> idx=0, FETCH; WRAP=0 -> DONE.
//    - End marker at idx 0 with WRAP=1 -> DONE (avoids an endless empty loop).
//  - DONE (1 cycle): done=1, busy=1 -> IDLE.
//  - Latency: start accepted at edge k -> tbl_rd in cycle k+1 -> out_valid from cycle k+2+RD_LAT.
//    Handshake at cycle h -> next tbl_rd in cycle h+1. Peak rate: one entry per RD_LAT+2 cycles.
//  - out_x/out_y/out_id/out_idx keep their last captured value after out_valid drops, until the next capture or reset.
//  - stop=1 in any non-IDLE state -> IDLE next cycle; out_valid=0; no done pulse; any in-flight capture is discarded.
//  - stop and start asserted together in IDLE: stop wins, walk does not begin.
//  - Handshake in the same cycle as stop: the entry counts as consumed, but stop still wins the state change.
//  - idx never exceeds N_ENTRIES-1, including for non-power-of-two depths.
// STRUCTURE
//  - Package note_seq_pkg: state enum typedef (IDLE, FETCH, WAIT, PRESENT, DONE) and function is_end_mark(x).
//  - One sub-module, rd_latency_pipe: an RD_LAT-deep shift register of tbl_rd producing the capture strobe.
//    Cleared by reset and by stop.
//  - The ROMs are external; the integration top instantiates them and connects tbl_*.
// TESTING
//  1. N=4, RD_LAT=1, WRAP=0, out_ready=1, ROM x={10,20,30,40}:
//     start -> out_valid at cycles 3,6,9,12 with out_x 10..40, out_last only on 40, done at cycle 13, then busy=0.
//  2. out_ready held 0 for 5 cycles in PRESENT -> out_* stable and no tbl_rd; out_ready=1 -> tbl_rd the next cycle.
//  3. WRAP=1, N=3 -> out_idx sequence 0,1,2,0,1 with no done pulse; stop -> busy=0 the next cycle.
//  4. USE_END_MARK=1, ROM x={5,255,7,8} -> only x=5 is presented, then done; WRAP=1 with x[0]=255 -> immediate done.
//  5. RD_LAT=3 -> tbl_rd at cycle 1, out_valid at cycle 5.
//     Reset asserted while in WAIT -> all outputs 0 next cycle; the late ROM data is not captured.
//  6. start and stop asserted together in IDLE -> busy stays 0.
//     start pulsed while in PRESENT -> ignored, out_idx unchanged.

Source files
------------

// File: rtl/note_table_sequencer_pkg.sv
// Shared state encoding and end-of-table detection for the note-table sequencer.
package note_seq_pkg;

    localparam int unsigned MAX_FIELD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    // True when the low w bits of x are all ones; fixed loop bound keeps it synthesizable.
    function automatic logic is_end_mark(input logic [MAX_FIELD_W-1:0] x, input int unsigned w);
        logic all_ones;
        all_ones = 1'b1;
        for (int unsigned i = 0; i < MAX_FIELD_W; i++) begin
            if ((i < w) && !x[i]) begin
                all_ones = 1'b0;
            end
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/note_table_sequencer_rd_latency_pipe.sv
// Delays the ROM read strobe by RD_LAT cycles to mark the cycle in which ROM data is valid.
module rd_latency_pipe
    import note_seq_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic rd_i,
    output logic capture_o
);

    logic [RD_LAT-1:0] pipe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= rd_i;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign capture_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/note_table_sequencer.sv
// Walks a note table held in external synchronous ROMs, presenting one entry per valid/ready handshake.
module note_table_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned N_ENTRIES    = 16,
    parameter int unsigned X_W          = 8,
    parameter int unsigned Y_W          = 8,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned RD_LAT       = 1,
    parameter bit          WRAP         = 1'b0,
    parameter bit          USE_END_MARK = 1'b1,
    localparam int unsigned IDX_W       = $clog2(N_ENTRIES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic             tbl_rd,
    output logic [IDX_W-1:0] tbl_addr,
    input  logic [X_W-1:0]   tbl_x,
    input  logic [Y_W-1:0]   tbl_y,
    input  logic [ID_W-1:0]  tbl_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic [ID_W-1:0]  out_id,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             tbl_rd_q;
    logic             out_valid_q;
    logic [X_W-1:0]   out_x_q;
    logic [Y_W-1:0]   out_y_q;
    logic [ID_W-1:0]  out_id_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_last_q;
    logic             busy_q;
    logic             done_q;

    logic             capture;
    logic             mark_d;
    logic             at_last_d;
    logic [IDX_W-1:0] idx_d;

    rd_latency_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk_i    (clock),
        .rst_i    (reset),
        .clr_i    (stop),
        .rd_i     (tbl_rd_q),
        .capture_o(capture)
    );

    // idx_d saturates back to 0 at the last entry, so non-power-of-two depths never overrun.
    always_comb begin
        mark_d    = USE_END_MARK && is_end_mark(MAX_FIELD_W'(tbl_x), X_W);
        at_last_d = (idx_q == LAST_IDX);
        idx_d     = at_last_d ? '0 : idx_q + IDX_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tbl_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_id_q    <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tbl_rd_q <= 1'b0;
            done_q   <= 1'b0;
            if (stop) begin
                if (state_q != IDLE) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            idx_q    <= '0;
                            tbl_rd_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= FETCH;
                        end
                    end
                    FETCH: begin
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if (capture) begin
                            if (mark_d) begin
                                // An end marker at index 0 under WRAP would loop forever on an empty table.
                                if (WRAP && (idx_q != '0)) begin
                                    idx_q    <= '0;
                                    tbl_rd_q <= 1'b1;
                                    state_q  <= FETCH;
                                end else begin
                                    done_q  <= 1'b1;
                                    state_q <= DONE;
                                end
                            end else begin
                                out_x_q     <= tbl_x;
                                out_y_q     <= tbl_y;
                                out_id_q    <= tbl_id;
                                out_idx_q   <= idx_q;
                                out_last_q  <= !WRAP && at_last_d;
                                out_valid_q <= 1'b1;
                                state_q     <= PRESENT;
                            end
                        end
                    end
                    PRESENT: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            if (!at_last_d || WRAP) begin
                                idx_q    <= idx_d;
                                tbl_rd_q <= 1'b1;
                                state_q  <= FETCH;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tbl_rd    = tbl_rd_q;
    assign tbl_addr  = idx_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_id    = out_id_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_note_table_sequencer.sv
// Directed bench: three sequencer configurations, each fed by a small behavioural ROM.
module tb_note_table_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: N=4, RD_LAT=1, one-shot
    logic       a_rst, a_start, a_stop, a_ready;
    logic       a_tbl_rd, a_valid, a_last, a_busy, a_done;
    logic [1:0] a_tbl_addr, a_idx, a_tbl_id, a_id;
    logic [7:0] a_tbl_x, a_tbl_y, a_x, a_y;
    logic [7:0] a_rom_x [4];
    logic [7:0] a_rom_y [4];
    logic [1:0] a_rom_id[4];
    logic [1:0] a_ap = '0;

    // Instance B: N=3, RD_LAT=1, wrap
    logic       b_rst, b_start, b_stop, b_ready;
    logic       b_tbl_rd, b_valid, b_last, b_busy, b_done;
    logic [1:0] b_tbl_addr, b_idx, b_tbl_id, b_id;
    logic [7:0] b_tbl_x, b_tbl_y, b_x, b_y;
    logic [7:0] b_rom_x [3];
    logic [1:0] b_ap = '0;

    // Instance C: N=4, RD_LAT=3, one-shot
    logic       c_rst, c_start, c_stop, c_ready;
    logic       c_tbl_rd, c_valid, c_last, c_busy, c_done;
    logic [1:0] c_tbl_addr, c_idx, c_tbl_id, c_id;
    logic [7:0] c_tbl_x, c_tbl_y, c_x, c_y;
    logic [7:0] c_rom_x [4];
    logic [1:0] c_a1 = '0, c_a2 = '0, c_a3 = '0;

    always @(posedge clock) begin
        if (a_tbl_rd) a_ap <= a_tbl_addr;
        if (b_tbl_rd) b_ap <= b_tbl_addr;
        if (c_tbl_rd) c_a1 <= c_tbl_addr;
        c_a2 <= c_a1;
        c_a3 <= c_a2;
    end

    assign a_tbl_x  = a_rom_x[a_ap];
    assign a_tbl_y  = a_rom_y[a_ap];
    assign a_tbl_id = a_rom_id[a_ap];
    assign b_tbl_x  = b_rom_x[b_ap];
    assign b_tbl_y  = 8'd0;
    assign b_tbl_id = 2'd0;
    assign c_tbl_x  = c_rom_x[c_a3];
    assign c_tbl_y  = 8'd7;
    assign c_tbl_id = 2'd1;

    note_table_sequencer #(
        .N_ENTRIES(4), .X_W(8), .Y_W(8), .ID_W(2), .RD_LAT(1), .WRAP(1'b0), .USE_END_MARK(1'b1)
    ) u_a (
        .clock(clock), .reset(a_rst), .start(a_start), .stop(a_stop),
        .tbl_rd(a_tbl_rd), .tbl_addr(a_tbl_addr), .tbl_x(a_tbl_x), .tbl_y(a_tbl_y), .tbl_id(a_tbl_id),
        .out_valid(a_valid), .out_ready(a_ready), .out_x(a_x), .out_y(a_y), .out_id(a_id),
        .out_idx(a_idx), .out_last(a_last), .busy(a_busy), .done(a_done)
    );

    note_table_sequencer #(
        .N_ENTRIES(3), .X_W(8), .Y_W(8), .ID_W(2), .RD_LAT(1), .WRAP(1'b1), .USE_END_MARK(1'b1)
    ) u_b (
        .clock(clock), .reset(b_rst), .start(b_start), .stop(b_stop),
        .tbl_rd(b_tbl_rd), .tbl_addr(b_tbl_addr), .tbl_x(b_tbl_x), .tbl_y(b_tbl_y), .tbl_id(b_tbl_id),
        .out_valid(b_valid), .out_ready(b_ready), .out_x(b_x), .out_y(b_y), .out_id(b_id),
        .out_idx(b_idx), .out_last(b_last), .busy(b_busy), .done(b_done)
    );

    note_table_sequencer #(
        .N_ENTRIES(4), .X_W(8), .Y_W(8), .ID_W(2), .RD_LAT(3), .WRAP(1'b0), .USE_END_MARK(1'b1)
    ) u_c (
        .clock(clock), .reset(c_rst), .start(c_start), .stop(c_stop),
        .tbl_rd(c_tbl_rd), .tbl_addr(c_tbl_addr), .tbl_x(c_tbl_x), .tbl_y(c_tbl_y), .tbl_id(c_tbl_id),
        .out_valid(c_valid), .out_ready(c_ready), .out_x(c_x), .out_y(c_y), .out_id(c_id),
        .out_idx(c_idx), .out_last(c_last), .busy(c_busy), .done(c_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {a_start, a_stop, a_ready} = '0;
        {b_start, b_stop, b_ready} = '0;
        {c_start, c_stop, c_ready} = '0;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_rom_x[i]  = 8'(10 * (i + 1));
            a_rom_y[i]  = 8'(i + 1);
            a_rom_id[i] = 2'(3 - i);
            c_rom_x[i]  = 8'(100 + i);
        end
        for (int i = 0; i < 3; i++) b_rom_x[i] = 8'(11 * (i + 1));

        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(negedge clock);
        check("rst_valid", a_valid, 0);
        check("rst_tbl_rd", a_tbl_rd, 0);
        check("rst_addr", a_tbl_addr, 0);
        check("rst_x", a_x, 0);
        check("rst_y", a_y, 0);
        check("rst_id", a_id, 0);
        check("rst_idx", a_idx, 0);
        check("rst_last", a_last, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_c_busy", c_busy, 0);
        tick();

        // Full one-shot walk, consumer always ready
        a_ready = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            check($sformatf("t1_valid_c%0d", c), a_valid, (c % 3 == 0) && (c <= 12));
            check($sformatf("t1_rd_c%0d", c), a_tbl_rd, (c % 3 == 1) && (c <= 10));
            check($sformatf("t1_done_c%0d", c), a_done, c == 13);
            check($sformatf("t1_busy_c%0d", c), a_busy, c <= 13);
            if ((c % 3 == 1) && (c <= 10)) check($sformatf("t1_addr_c%0d", c), a_tbl_addr, (c - 1) / 3);
            if ((c % 3 == 0) && (c <= 12)) begin
                check($sformatf("t1_x_c%0d", c), a_x, 10 * (c / 3));
                check($sformatf("t1_y_c%0d", c), a_y, c / 3);
                check($sformatf("t1_id_c%0d", c), a_id, 4 - c / 3);
                check($sformatf("t1_idx_c%0d", c), a_idx, c / 3 - 1);
                check($sformatf("t1_last_c%0d", c), a_last, c == 12);
            end
            tick();
        end

        // Backpressure, start ignored in PRESENT, then stop during FETCH
        a_ready = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            a_start = (c == 5);
            a_ready = (c >= 8);
            a_stop  = (c == 9);
            @(negedge clock);
            if (c >= 3 && c <= 8) begin
                check($sformatf("t2_valid_c%0d", c), a_valid, 1);
                check($sformatf("t2_x_c%0d", c), a_x, 10);
                check($sformatf("t2_idx_c%0d", c), a_idx, 0);
                check($sformatf("t2_rd_c%0d", c), a_tbl_rd, 0);
            end
            if (c == 9) begin
                check("t2_rd_after_ready", a_tbl_rd, 1);
                check("t2_addr_after_ready", a_tbl_addr, 1);
                check("t2_valid_after_ready", a_valid, 0);
            end
            if (c == 10) begin
                check("t2_stop_busy", a_busy, 0);
                check("t2_stop_rd", a_tbl_rd, 0);
                check("t2_stop_done", a_done, 0);
                check("t2_stop_valid", a_valid, 0);
            end
            tick();
        end
        a_start = 1'b0; a_stop = 1'b0; a_ready = 1'b1;
        tick();

        // End marker at index 1 in one-shot mode
        a_rom_x[1] = 8'd255; a_rom_x[0] = 8'd5; a_rom_x[2] = 8'd7; a_rom_x[3] = 8'd8;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            check($sformatf("t4_valid_c%0d", c), a_valid, c == 3);
            check($sformatf("t4_done_c%0d", c), a_done, c == 6);
            check($sformatf("t4_busy_c%0d", c), a_busy, c <= 6);
            check($sformatf("t4_rd_c%0d", c), a_tbl_rd, (c == 1) || (c == 4));
            if (c == 3 || c == 8) check($sformatf("t4_x_c%0d", c), a_x, 5);
            tick();
        end

        // start and stop together in IDLE
        a_start = 1'b1; a_stop = 1'b1;
        tick();
        a_start = 1'b0; a_stop = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            check($sformatf("t6_busy_c%0d", c), a_busy, 0);
            check($sformatf("t6_rd_c%0d", c), a_tbl_rd, 0);
            tick();
        end

        // Wrap mode, N=3, stop together with a handshake
        b_ready = 1'b1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            b_stop = (c == 15);
            @(negedge clock);
            if (c <= 15) begin
                check($sformatf("t3_valid_c%0d", c), b_valid, c % 3 == 0);
                check($sformatf("t3_rd_c%0d", c), b_tbl_rd, c % 3 == 1);
                check($sformatf("t3_done_c%0d", c), b_done, 0);
                if (c % 3 == 0) begin
                    check($sformatf("t3_idx_c%0d", c), b_idx, (c / 3 - 1) % 3);
                    check($sformatf("t3_x_c%0d", c), b_x, 11 * ((c / 3 - 1) % 3 + 1));
                    check($sformatf("t3_last_c%0d", c), b_last, 0);
                end
            end else begin
                check("t3_stop_busy", b_busy, 0);
                check("t3_stop_valid", b_valid, 0);
                check("t3_stop_rd", b_tbl_rd, 0);
                check("t3_stop_done", b_done, 0);
                check("t3_stop_idx_hold", b_idx, 1);
            end
            tick();
        end
        b_stop = 1'b0;

        // Wrap mode with end marker at index 0: immediate done
        b_rom_x[0] = 8'd255;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            check($sformatf("t4b_rd_c%0d", c), b_tbl_rd, c == 1);
            check($sformatf("t4b_valid_c%0d", c), b_valid, 0);
            check($sformatf("t4b_done_c%0d", c), b_done, c == 3);
            check($sformatf("t4b_busy_c%0d", c), b_busy, c <= 3);
            tick();
        end

        // RD_LAT=3 timing, then reset while waiting on a read
        c_ready = 1'b0; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            c_ready = (c == 5);
            c_rst   = (c == 8);
            @(negedge clock);
            check($sformatf("t5_rd_c%0d", c), c_tbl_rd, (c == 1) || (c == 6));
            check($sformatf("t5_valid_c%0d", c), c_valid, c == 5);
            check($sformatf("t5_busy_c%0d", c), c_busy, c <= 8);
            if (c == 5) begin
                check("t5_x_first", c_x, 100);
                check("t5_y_first", c_y, 7);
                check("t5_idx_first", c_idx, 0);
            end
            if (c >= 9) begin
                check($sformatf("t5_rst_x_c%0d", c), c_x, 0);
                check($sformatf("t5_rst_y_c%0d", c), c_y, 0);
                check($sformatf("t5_rst_id_c%0d", c), c_id, 0);
                check($sformatf("t5_rst_done_c%0d", c), c_done, 0);
            end
            tick();
        end
        c_rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
